// File: rtl/gamma_inv_lut.sv
// gamma_inv_lut -- inverse-gamma (de-gamma) stage for the ISP gamma path.
//
// Maps 12-bit gamma-encoded pixels back to 8-bit linear codes. The forward
// curve is a monotone 256 x 12-bit table. For each pixel the block returns
// the largest index i with LUT[i] <= pixel, found by an 8-step binary search
// with one step per pipeline stage. The table is double-banked: the host
// writes the shadow bank, and a commit swaps the banks at the next frame
// start so that a whole frame always sees one coherent curve.
//
// Ports
//   I_clk, I_rst_n          pixel clock, synchronous active-low reset
//   I_vs, I_hs, I_de        video sync / data enable in
//   I_data      [11:0]      gamma-encoded pixel
//   I_tbl_wr                shadow-bank write strobe
//   I_tbl_addr  [7:0]       table index
//   I_tbl_wdata [11:0]      table value
//   I_tbl_commit            one-cycle request to swap banks at next frame start
//   O_vs, O_hs, O_de        sync / enable delayed by 8 cycles
//   O_data      [7:0]       linear pixel
//   O_tbl_pending           commit accepted, swap not yet performed
//   O_bank                  currently active bank
module gamma_inv_lut #(
  parameter int INIT_SHIFT = 4,
  parameter bit VS_POL     = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_vs,
  input  logic        I_hs,
  input  logic        I_de,
  input  logic [11:0] I_data,
  input  logic        I_tbl_wr,
  input  logic [7:0]  I_tbl_addr,
  input  logic [11:0] I_tbl_wdata,
  input  logic        I_tbl_commit,
  output logic        O_vs,
  output logic        O_hs,
  output logic        O_de,
  output logic [7:0]  O_data,
  output logic        O_tbl_pending,
  output logic        O_bank
);

  localparam int STAGES = 8;

  // Two table banks; each search stage reads one entry of the bank that
  // was active when its pixel entered the pipeline.
  logic [11:0] lut [2][256];

  logic bank;
  logic pending;
  logic vs_d;
  logic frame_start;

  // Pixel value and bank select travel with the pixel; the last stage only
  // needs the index, so these stop one short of the pipeline end.
  logic [11:0] x_p    [STAGES-1];
  logic        bank_p [STAGES-1];
  logic [7:0]  idx_p  [STAGES];
  logic        vs_p   [STAGES];
  logic        hs_p   [STAGES];
  logic        vld_p  [STAGES];

  logic [7:0]  idx_n  [STAGES];

  assign frame_start = (I_vs == VS_POL) && (vs_d != VS_POL);

  // Table storage and bank control.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 256; i++) begin
          lut[b][i] <= 12'(i << INIT_SHIFT);
        end
      end
      bank    <= 1'b0;
      pending <= 1'b0;
      vs_d    <= !VS_POL;
    end else begin
      // Always the bank that is shadow before this edge; on a swap edge
      // that is the bank becoming active.
      if (I_tbl_wr) begin
        lut[!bank][I_tbl_addr] <= I_tbl_wdata;
      end
      if (frame_start && (pending || I_tbl_commit)) begin
        bank    <= !bank;
        pending <= 1'b0;
      end else if (I_tbl_commit) begin
        pending <= 1'b1;
      end
      vs_d <= I_vs;
    end
  end

  // One binary-search step per stage: try setting the next lower bit of the
  // index and keep it if the table entry there does not exceed the pixel.
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [11:0] x_in;
      logic [7:0]  idx_in;
      logic        bank_in;
      logic [7:0]  cand;

      if (k == 0) begin : g_first
        assign x_in    = I_data;
        assign idx_in  = 8'd0;
        assign bank_in = bank;
      end else begin : g_rest
        assign x_in    = x_p[k-1];
        assign idx_in  = idx_p[k-1];
        assign bank_in = bank_p[k-1];
      end

      assign cand     = idx_in | (8'h80 >> k);
      assign idx_n[k] = (lut[bank_in][cand] <= x_in) ? cand : idx_in;
    end
  endgenerate

  // Stage registers _p0 .. _p7; syncs ride alongside the search.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        idx_p[s] <= 8'd0;
        vs_p[s]  <= !VS_POL;
        hs_p[s]  <= 1'b0;
        vld_p[s] <= 1'b0;
      end
      for (int s = 0; s < STAGES - 1; s++) begin
        x_p[s]    <= 12'd0;
        bank_p[s] <= 1'b0;
      end
    end else begin
      idx_p[0]  <= idx_n[0];
      x_p[0]    <= I_data;
      bank_p[0] <= bank;
      vs_p[0]   <= I_vs;
      hs_p[0]   <= I_hs;
      vld_p[0]  <= I_de;
      for (int s = 1; s < STAGES; s++) begin
        idx_p[s] <= idx_n[s];
        vs_p[s]  <= vs_p[s-1];
        hs_p[s]  <= hs_p[s-1];
        vld_p[s] <= vld_p[s-1];
      end
      for (int s = 1; s < STAGES - 1; s++) begin
        x_p[s]    <= x_p[s-1];
        bank_p[s] <= bank_p[s-1];
      end
    end
  end

  assign O_vs          = vs_p[STAGES-1];
  assign O_hs          = hs_p[STAGES-1];
  assign O_de          = vld_p[STAGES-1];
  assign O_data        = idx_p[STAGES-1];
  assign O_tbl_pending = pending;
  assign O_bank        = bank;

endmodule

// File: tb/tb_gamma_inv_lut.sv
// tb_gamma_inv_lut -- scoreboard bench for gamma_inv_lut.
// Expected outputs are queued when a pixel is driven and compared when it
// emerges 8 cycles later. Bank/pending state is checked every cycle against
// a behavioural model of the table banks.
module tb_gamma_inv_lut;

  logic        clk = 1'b0;
  logic        rst_n, vs, hs, de;
  logic [11:0] data;
  logic        tbl_wr;
  logic [7:0]  tbl_addr;
  logic [11:0] tbl_wdata;
  logic        tbl_commit;
  logic        o_vs, o_hs, o_de;
  logic [7:0]  o_data;
  logic        o_tbl_pending, o_bank;

  gamma_inv_lut #(.INIT_SHIFT(4), .VS_POL(1'b1)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_hs(hs), .I_de(de),
    .I_data(data), .I_tbl_wr(tbl_wr), .I_tbl_addr(tbl_addr),
    .I_tbl_wdata(tbl_wdata), .I_tbl_commit(tbl_commit),
    .O_vs(o_vs), .O_hs(o_hs), .O_de(o_de), .O_data(o_data),
    .O_tbl_pending(o_tbl_pending), .O_bank(o_bank)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       vs, hs, de;
    logic [7:0] d;
    bit         cd;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  // Behavioural model of the banks and swap control.
  int   m_lut [2][256];
  bit   m_bank, m_pending, m_vs_prev;

  function automatic int inv(input bit b, input int x);
    for (int i = 255; i >= 0; i--) begin
      if (m_lut[b][i] <= x) return i;
    end
    return 0;
  endfunction

  function automatic int gam_curve(input int i);
    if (i < 128) return 1 + (1712 * i) / 127;
    return 1730 + (2356 * (i - 128)) / 127;
  endfunction

  // One clock: queue the expectation, step the model at the edge, check
  // bank state at the following negedge. expd < 0 means use the model.
  task automatic cycle(input int expd = -1);
    bit fs;
    if (!rst_n) begin
      sbq.delete();
      for (int i = 0; i < 8; i++) begin
        sbq.push_back('{vs: 1'b0, hs: 1'b0, de: 1'b0, d: 8'd0, cd: (i == 0)});
      end
    end else begin
      sbq.push_back('{vs: vs, hs: hs, de: de,
                      d: 8'((expd >= 0) ? expd : inv(m_bank, int'(data))),
                      cd: de});
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 256; i++) m_lut[b][i] = (i << 4) & 12'hFFF;
      m_bank = 0; m_pending = 0; m_vs_prev = 0;
    end else begin
      fs = vs && !m_vs_prev;
      if (tbl_wr) m_lut[!m_bank][tbl_addr] = int'(tbl_wdata);
      if (fs && (m_pending || tbl_commit)) begin
        m_bank = !m_bank; m_pending = 0;
      end else if (tbl_commit) begin
        m_pending = 1;
      end
      m_vs_prev = vs;
    end
    @(negedge clk);
    chk("bank", int'(o_bank), int'(m_bank));
    chk("pending", int'(o_tbl_pending), int'(m_pending));
  endtask

  task automatic pix(input logic [11:0] x, input int expd = -1);
    de = 1'b1; data = x;
    cycle(expd);
    de = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic vs_edge();
    vs = 1'b1; idle(2); vs = 1'b0; idle(2);
  endtask

  // Scoreboard consumer: the entry queued before edge E emerges after E+7.
  always @(posedge clk) begin
    #1;
    if (sbq.size() >= 8) begin
      e = sbq.pop_front();
      chk("o_vs", int'(o_vs), int'(e.vs));
      chk("o_hs", int'(o_hs), int'(e.hs));
      chk("o_de", int'(o_de), int'(e.de));
      if (e.cd) chk("o_data", int'(o_data), int'(e.d));
    end
  end

  initial begin
    rst_n = 0; vs = 0; hs = 0; de = 0; data = 0;
    tbl_wr = 0; tbl_addr = 0; tbl_wdata = 0; tbl_commit = 0;
    m_bank = 0; m_pending = 0; m_vs_prev = 0;

    idle(3);
    rst_n = 1;
    idle(2);

    // Reset curve: inverse is pixel >> 4
    pix(12'h000, 8'h00);
    pix(12'h7FF, 8'h7F);
    pix(12'hFFF, 8'hFF);
    idle(10);

    // Load gamma curve into shadow bank 1 and commit
    tbl_wr = 1;
    for (int i = 0; i < 256; i++) begin
      tbl_addr = 8'(i); tbl_wdata = 12'(gam_curve(i));
      cycle();
    end
    tbl_wr = 0;
    tbl_commit = 1; cycle(); tbl_commit = 0;
    pix(12'h7FF, 8'h7F);
    pix(12'd1730, 8'd108);
    idle(3);
    vs_edge();
    chk("bank_after_swap", int'(o_bank), 1);
    pix(12'd1730, 8'd128);
    pix(12'd1729, 8'd127);
    pix(12'd0,    8'd0);
    pix(12'd4095, 8'd255);
    idle(10);

    // Frame coherence: rewrite bank 0 with LUT[i]=8*i during active video,
    // commit mid-frame, keep streaming across the next vsync edge.
    for (int i = 0; i < 300; i++) begin
      hs = ((i % 64) < 4);
      de = !hs;
      data = 12'($urandom_range(0, 4095));
      tbl_wr = (i < 256);
      tbl_addr = 8'(i);
      tbl_wdata = 12'(8 * i);
      tbl_commit = (i == 128);
      vs = (i >= 264) && (i < 268);
      cycle();
    end
    tbl_wr = 0; tbl_commit = 0; hs = 0; vs = 0; de = 0;
    idle(4);

    // Commit on the vsync edge itself, with a write on the swap cycle that
    // lands in the bank becoming active (bank 1, gamma curve).
    vs = 1; tbl_commit = 1; tbl_wr = 1; tbl_addr = 8'd128; tbl_wdata = 12'd1714;
    cycle();
    tbl_commit = 0; tbl_wr = 0;
    chk("bank_commit_on_edge", int'(o_bank), 1);
    pix(12'd1720, 8'd128);
    pix(12'd1713, 8'd127);
    vs = 0;
    idle(10);

    // Second commit while pending: exactly one swap
    tbl_commit = 1; cycle(); tbl_commit = 0;
    idle(3);
    tbl_commit = 1; cycle(); tbl_commit = 0;
    idle(3);
    vs_edge();
    chk("bank_single_swap", int'(o_bank), 0);
    vs_edge();
    chk("bank_no_commit", int'(o_bank), 0);
    pix(12'd2047, 8'd255);
    pix(12'd100, 8'd12);
    tbl_commit = 1; cycle(); tbl_commit = 0;
    vs_edge();
    chk("bank_back_to_1", int'(o_bank), 1);
    idle(10);

    // Reset while streaming with a commit pending
    tbl_commit = 1; cycle(); tbl_commit = 0;
    for (int i = 0; i < 5; i++) pix(12'($urandom_range(0, 4095)));
    de = 1; data = 12'hABC; rst_n = 0;
    cycle();
    rst_n = 1; de = 0;
    chk("pending_after_rst", int'(o_tbl_pending), 0);
    chk("bank_after_rst", int'(o_bank), 0);
    pix(12'h100, 8'h10);
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
